sound_mixer: RTL and testbench
==============================

Name: sound_mixer

Overview:
- Sits directly downstream of the four sound channel generators (square1, square2, wave, noise).
- On each output-sample strobe it captures one 4-bit amplitude per channel and routes each channel to left/right per NR51.
- Sums, scales by the NR50 master volumes, and presents a signed stereo sample pair to the audio output stage over a valid/ready handshake.
- Counts samples it had to drop because the consumer stalled.

Parameters:
- OUT_W, 16, width of each signed output sample; must be >= 10 + OUT_SHIFT.
- OUT_SHIFT, 6, left shift applied to the scaled sum to reach output range.

Ports:
- system_clock  input  1  block clock.
- reset  input  1  asynchronous, active-low reset.
- sample_tick  input  1  one-cycle strobe requesting a new output sample.
- ch1_sample  input  4  channel 1 amplitude, unsigned 0..15.
- ch2_sample  input  4  channel 2 amplitude.
- ch3_sample  input  4  channel 3 amplitude.
- ch4_sample  input  4  channel 4 amplitude.
- NR50  input  8  bits 6:4 left volume, bits 2:0 right volume.
- NR51  input  8  bits 7:4 left enable (ch4..ch1), bits 3:0 right enable (ch4..ch1); bit0 = ch1 right, bit4 = ch1 left.
- NR52  input  8  bit7 master sound enable.
- out_left  output  OUT_W  signed left sample.
- out_right  output  OUT_W  signed right sample.
- out_valid  output  1  output pair valid.
- out_ready  input  1  consumer accepts the pair when high with out_valid.
- overrun_count  output  8  saturating count of dropped ticks.

Behaviour:
- Reset (async, reset=0): state IDLE; out_left, out_right, out_valid, overrun_count, accumulators and channel index all 0.
- FSM states: IDLE, ACC, SCALE, HOLD.
- IDLE, edge with sample_tick=1 (E0):
  - Capture ch1..ch4_sample, NR50, NR51 and NR52 into shadow registers; later input changes do not affect this sample.
  - Clear both accumulators, index=0, go to ACC.
- ACC, edges E1..E4: one channel per edge, ch1 first.
  - Bipolar value s = 2*x - 15, range -15..+15.
  - Add s to the left accumulator if its left enable bit is set, and to the right accumulator if its right enable bit is set.
  - Accumulators are 7-bit signed, range -60..+60.
  - After ch4, go to SCALE.
- SCALE, edge E5:
  - Left = accL * (NR50[6:4]+1); right = accR * (NR50[2:0]+1); 10-bit signed, range -480..+480.
  - Shift left by OUT_SHIFT, sign-extend to OUT_W, register to out_left/out_right.
  - Set out_valid=1 and go to HOLD.
  - If the shadowed NR52 bit7=0, both outputs are 0 but out_valid still asserts.
- HOLD:
  - out_left, out_right and out_valid are held stable until an edge with out_ready=1.
  - On that edge, out_valid=0, go to IDLE; the outputs keep their last value.
  - out_ready has no effect outside HOLD.
- Latency: out_valid is visible after E5, i.e. 5 cycles after the tick edge. Minimum tick spacing without loss is 7 cycles with out_ready tied high.
- Overrun: sample_tick=1 on an edge in ACC, SCALE or HOLD is dropped and overrun_count increments.
  - This includes the HOLD edge on which the handshake completes; that tick is also dropped.
  - overrun_count saturates at 255 and clears only on reset.
- Reset asserted mid-operation: the in-flight sample is abandoned and all outputs return to reset values immediately.

Test Plan:
- All channels 15, NR51=0xFF, NR50=0x77, NR52=0x80, tick, out_ready=1 -> out_valid rises 5 cycles after the tick edge; out_left = out_right = 0x7800 (30720).
- ch1=0, others 15, NR51=0x10, NR50=0x00, NR52=0x80 -> out_left = 0xFC40 (-960), out_right = 0x0000.
- NR52=0x00 with any inputs -> out_valid asserts with both outputs 0x0000.
- Hold out_ready=0 for 20 cycles and pulse sample_tick 3 times during HOLD -> outputs stay stable, overrun_count=3; out_ready=1 then completes the handshake, and the next tick in IDLE is processed normally.
- Change ch1_sample and NR50 on E2 after a tick -> the result matches the values captured at E0.
- Assert reset during ACC -> out_valid=0, outputs 0, overrun_count=0; after release, a new tick produces a correct sample.

Source files
------------

// File: rtl/sound_mixer.sv
// Stereo mixer for the four sound channels: captures one amplitude per channel on
// sample_tick, pans per NR51, scales per NR50 and hands a signed pair downstream.
module sound_mixer #(
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 6
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic [3:0]              ch1_sample,
  input  logic [3:0]              ch2_sample,
  input  logic [3:0]              ch3_sample,
  input  logic [3:0]              ch4_sample,
  input  logic [7:0]              NR50,
  input  logic [7:0]              NR51,
  input  logic [7:0]              NR52,
  output logic signed [OUT_W-1:0] out_left,
  output logic signed [OUT_W-1:0] out_right,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              overrun_count,
  output logic [1:0]              state_dbg
);

  // Handshake: a pair transfers on a clock edge where out_valid and out_ready are both
  // high; out_valid stays high and out_left/out_right stay stable until that edge.

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, SCALE = 2'd2, HOLD = 2'd3} state_t;

  state_t state, state_nx;

  logic [3:0][3:0]        ch_sh;
  logic [2:0]             vol_l_sh, vol_r_sh;
  logic [7:0]             en_sh;
  logic                   master_sh;
  logic [1:0]             idx;
  logic signed [6:0]      acc_l, acc_r;

  logic [3:0]             cur_x;
  logic signed [5:0]      s_val;
  logic signed [6:0]      s_ext;
  logic [3:0]             gain_l, gain_r;
  logic signed [9:0]      mix_l, mix_r;
  logic signed [OUT_W-1:0] scaled_l, scaled_r;
  logic                   unused_bits;

  assign unused_bits = ^{NR50[7], NR50[3], NR52[6:0]};
  assign state_dbg   = state;

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_tick) state_nx = ACC;
      ACC:     if (idx == 2'd3) state_nx = SCALE;
      SCALE:   state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bipolar channel value 2*x-15, then volume gain 1..8 and shift to output range.
  always_comb begin
    cur_x    = ch_sh[idx];
    s_val    = $signed({1'b0, cur_x, 1'b0}) - 6'sd15;
    s_ext    = {s_val[5], s_val};
    gain_l   = {1'b0, vol_l_sh} + 4'd1;
    gain_r   = {1'b0, vol_r_sh} + 4'd1;
    mix_l    = $signed({{3{acc_l[6]}}, acc_l}) * $signed({6'd0, gain_l});
    mix_r    = $signed({{3{acc_r[6]}}, acc_r}) * $signed({6'd0, gain_r});
    scaled_l = $signed({{(OUT_W-10){mix_l[9]}}, mix_l}) <<< OUT_SHIFT;
    scaled_r = $signed({{(OUT_W-10){mix_r[9]}}, mix_r}) <<< OUT_SHIFT;
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      ch_sh         <= '0;
      vol_l_sh      <= '0;
      vol_r_sh      <= '0;
      en_sh         <= '0;
      master_sh     <= 1'b0;
      idx           <= '0;
      acc_l         <= '0;
      acc_r         <= '0;
      out_left      <= '0;
      out_right     <= '0;
      out_valid     <= 1'b0;
      overrun_count <= '0;
    end else begin
      // Any tick not taken in IDLE is lost, including the one on the handshake edge.
      if (sample_tick && state != IDLE && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            ch_sh     <= {ch4_sample, ch3_sample, ch2_sample, ch1_sample};
            vol_l_sh  <= NR50[6:4];
            vol_r_sh  <= NR50[2:0];
            en_sh     <= NR51;
            master_sh <= NR52[7];
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
          end
        end
        ACC: begin
          if (en_sh[{1'b1, idx}]) acc_l <= acc_l + s_ext;
          if (en_sh[{1'b0, idx}]) acc_r <= acc_r + s_ext;
          idx <= idx + 2'd1;
        end
        SCALE: begin
          out_left  <= master_sh ? scaled_l : '0;
          out_right <= master_sh ? scaled_r : '0;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// Self-checking bench for sound_mixer: reference model feeds an expected queue that is
// drained as each output pair appears.
module tb_sound_mixer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic rdy = 1'b1;
  logic [3:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic [7:0] n50 = '0, n51 = '0, n52 = '0;
  logic signed [W-1:0] out_left, out_right;
  logic out_valid;
  logic [7:0] overrun_count;
  logic [1:0] state_dbg;

  int n_pass = 0;
  int n_total = 0;
  int exp_ovr = 0;
  logic [2*W-1:0] exp_q[$];

  sound_mixer #(.OUT_W(W), .OUT_SHIFT(6)) dut (
    .system_clock(clk), .reset(rst_n), .sample_tick(tick),
    .ch1_sample(c1), .ch2_sample(c2), .ch3_sample(c3), .ch4_sample(c4),
    .NR50(n50), .NR51(n51), .NR52(n52),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(rdy), .overrun_count(overrun_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2*W-1:0] model(input logic [3:0] a, b, c, d,
                                           input logic [7:0] v50, v51, v52);
    int x[4];
    int l, r, s;
    logic [W-1:0] lo, ro;
    x[0] = a; x[1] = b; x[2] = c; x[3] = d;
    l = 0; r = 0;
    for (int i = 0; i < 4; i++) begin
      s = 2 * x[i] - 15;
      if (v51[4+i]) l += s;
      if (v51[i])   r += s;
    end
    l = l * (int'(v50[6:4]) + 1) * 64;
    r = r * (int'(v50[2:0]) + 1) * 64;
    if (!v52[7]) begin l = 0; r = 0; end
    lo = l[W-1:0];
    ro = r[W-1:0];
    return {lo, ro};
  endfunction

  task automatic send_tick(input logic [3:0] a, b, c, d, input logic [7:0] v50, v51, v52);
    @(negedge clk);
    c1 = a; c2 = b; c3 = c; c4 = d; n50 = v50; n51 = v51; n52 = v52;
    tick = 1'b1;
    exp_q.push_back(model(a, b, c, d, v50, v51, v52));
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_hs(output int lat);
    rdy = 1'b1;
    lat = 0;
    while (out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #12;
    n_total++;
    if ({out_left, out_right, out_valid} !== {{2*W{1'b0}}, 1'b0})
      $display("FAIL reset_outputs: got %h/%h v=%b expected 0/0 v=0", out_left, out_right, out_valid);
    else n_pass++;
    n_total++;
    if (overrun_count !== 8'd0) $display("FAIL reset_overrun: got %0d expected 0", overrun_count);
    else n_pass++;
    n_total++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_scale;
    int lat;
    logic [2*W-1:0] exp;
    send_tick(4'd15, 4'd15, 4'd15, 4'd15, 8'h77, 8'hFF, 8'h80);
    wait_valid(lat);
    n_total++;
    if (lat !== 5) $display("FAIL full_latency: got %0d expected 5", lat);
    else n_pass++;
    exp = exp_q.pop_front();
    n_total++;
    if ({out_left, out_right} !== exp) $display("FAIL full_model: got %h expected %h", {out_left, out_right}, exp);
    else n_pass++;
    n_total++;
    if ({out_left, out_right} !== 32'h7800_7800) $display("FAIL full_value: got %h expected 78007800", {out_left, out_right});
    else n_pass++;
    release_hs(lat);
    n_total++;
    if (lat !== 1) $display("FAIL full_handshake: got %0d cycles expected 1", lat);
    else n_pass++;
  endtask

  task automatic test_left_only;
    int lat;
    logic [2*W-1:0] exp;
    send_tick(4'd0, 4'd15, 4'd15, 4'd15, 8'h00, 8'h10, 8'h80);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if ({out_left, out_right} !== exp || exp !== 32'hFC40_0000)
      $display("FAIL left_only: got %h expected fc400000 (model %h)", {out_left, out_right}, exp);
    else n_pass++;
    release_hs(lat);
  endtask

  task automatic test_master_off;
    int lat;
    logic [2*W-1:0] exp;
    send_tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd15, 4'd3,
              8'h77, 8'hF3, 8'h00);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if (lat !== 5 || {out_left, out_right} !== 32'h0 || exp !== 32'h0)
      $display("FAIL master_off: got lat=%0d %h expected lat=5 00000000", lat, {out_left, out_right});
    else n_pass++;
    release_hs(lat);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      send_tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                (i == 5) ? 8'h00 : 8'h80);
      wait_valid(lat);
      exp = exp_q.pop_front();
      n_total++;
      if (lat !== 5 || {out_left, out_right} !== exp)
        $display("FAIL b2b_%0d: got lat=%0d %h expected lat=5 %h", i, lat, {out_left, out_right}, exp);
      else n_pass++;
      release_hs(lat);
    end
    n_total++;
    if (overrun_count !== 8'(exp_ovr)) $display("FAIL b2b_overrun: got %0d expected %0d", overrun_count, exp_ovr);
    else n_pass++;
  endtask

  task automatic test_capture;
    int lat;
    logic [2*W-1:0] exp;
    send_tick(4'd12, 4'd1, 4'd9, 4'd6, 8'h52, 8'hB7, 8'h80);
    @(negedge clk);
    c1 = 4'd0; c2 = 4'd15; n50 = 8'h07; n51 = 8'h0F; n52 = 8'h00;
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if (lat !== 4 || {out_left, out_right} !== exp)
      $display("FAIL capture: got lat=%0d %h expected lat=4 %h", lat, {out_left, out_right}, exp);
    else n_pass++;
    release_hs(lat);
  endtask

  task automatic test_stall;
    int lat;
    logic [2*W-1:0] exp;
    rdy = 1'b0;
    send_tick(4'd3, 4'd14, 4'd7, 4'd10, 8'h35, 8'h6C, 8'h80);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if (lat !== 5 || {out_left, out_right} !== exp)
      $display("FAIL stall_first: got lat=%0d %h expected lat=5 %h", lat, {out_left, out_right}, exp);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tick = (i == 3 || i == 8 || i == 13);
      if (tick) exp_ovr++;
      @(posedge clk); #1;
      n_total++;
      if ({out_left, out_right, out_valid} !== {exp, 1'b1})
        $display("FAIL stall_stable_%0d: got %h v=%b expected %h v=1", i, {out_left, out_right}, out_valid, exp);
      else n_pass++;
    end
    @(negedge clk);
    tick = 1'b0;
    n_total++;
    if (overrun_count !== 8'(exp_ovr)) $display("FAIL stall_overrun: got %0d expected %0d", overrun_count, exp_ovr);
    else n_pass++;
    release_hs(lat);
    n_total++;
    if (lat !== 1) $display("FAIL stall_release: got %0d cycles expected 1", lat);
    else n_pass++;
    send_tick(4'd8, 4'd2, 4'd13, 4'd5, 8'h61, 8'h5A, 8'h80);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if (lat !== 5 || {out_left, out_right} !== exp)
      $display("FAIL stall_next: got lat=%0d %h expected lat=5 %h", lat, {out_left, out_right}, exp);
    else n_pass++;
    release_hs(lat);
  endtask

  task automatic test_handshake_tick;
    int lat;
    int seen;
    logic [2*W-1:0] exp;
    rdy = 1'b0;
    send_tick(4'd4, 4'd11, 4'd0, 4'd15, 8'h24, 8'hC3, 8'h80);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if ({out_left, out_right} !== exp) $display("FAIL hs_tick_value: got %h expected %h", {out_left, out_right}, exp);
    else n_pass++;
    @(negedge clk);
    rdy = 1'b1; tick = 1'b1;
    exp_ovr++;
    @(negedge clk);
    tick = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_total++;
    if (seen !== 0 || state_dbg !== 2'd0 || overrun_count !== 8'(exp_ovr))
      $display("FAIL hs_tick_drop: got valid_cycles=%0d state=%0d ovr=%0d expected 0/0/%0d",
               seen, state_dbg, overrun_count, exp_ovr);
    else n_pass++;
  endtask

  task automatic test_overrun_sat;
    int lat;
    logic [2*W-1:0] exp;
    rdy = 1'b0;
    send_tick(4'd15, 4'd15, 4'd15, 4'd15, 8'h77, 8'hFF, 8'h80);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if ({out_left, out_right} !== exp) $display("FAIL sat_value: got %h expected %h", {out_left, out_right}, exp);
    else n_pass++;
    @(negedge clk);
    tick = 1'b1;
    repeat (300) @(negedge clk);
    tick = 1'b0;
    exp_ovr = (exp_ovr + 300 > 255) ? 255 : exp_ovr + 300;
    n_total++;
    if (overrun_count !== 8'(exp_ovr)) $display("FAIL sat_count: got %0d expected %0d", overrun_count, exp_ovr);
    else n_pass++;
    release_hs(lat);
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [2*W-1:0] exp;
    send_tick(4'd9, 4'd9, 4'd9, 4'd9, 8'h11, 8'hFF, 8'h80);
    @(negedge clk);
    rst_n = 1'b0;
    exp = exp_q.pop_back();
    exp_ovr = 0;
    #1;
    n_total++;
    if ({out_left, out_right, out_valid} !== {{2*W{1'b0}}, 1'b0} || overrun_count !== 8'd0 || state_dbg !== 2'd0)
      $display("FAIL reset_mid: got %h v=%b ovr=%0d st=%0d expected 0 v=0 ovr=0 st=0",
               {out_left, out_right}, out_valid, overrun_count, state_dbg);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    send_tick(4'd2, 4'd13, 4'd6, 4'd11, 8'h43, 8'h96, 8'h80);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_total++;
    if (lat !== 5 || {out_left, out_right} !== exp)
      $display("FAIL reset_recover: got lat=%0d %h expected lat=5 %h", lat, {out_left, out_right}, exp);
    else n_pass++;
    release_hs(lat);
  endtask

  initial begin
    test_reset;
    test_full_scale;
    test_left_only;
    test_master_off;
    test_back_to_back;
    test_capture;
    test_stall;
    test_handshake_tick;
    test_overrun_sat;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
